// File: rtl/axis_master_pkt.sv
// Packet-aware AXI-Stream master: backend beats pass through an FWFT FIFO onto AXIS.
// TLAST comes from bk_last or from a per-packet beat count. Stall watchdog and done pulse go back to the backend.
module axis_master_pkt #(
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int RDY_TIMEOUT = 5
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          bk_valid,
    output logic                          bk_ready,
    input  logic [DATA_WIDTH-1:0]         bk_data,
    input  logic [DATA_WIDTH/8-1:0]       bk_tstrb,
    input  logic [DATA_WIDTH/8-1:0]       bk_tkeep,
    input  logic [USER_WIDTH-1:0]         bk_user,
    input  logic                          bk_last,
    input  logic                          cfg_auto_last,
    input  logic [7:0]                    cfg_pkt_len,
    input  logic                          flush,
    output logic                          bk_nordy,
    output logic                          bk_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          axis_tvalid,
    output logic [DATA_WIDTH-1:0]         axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]       axis_tkeep,
    output logic [USER_WIDTH-1:0]         axis_tuser,
    output logic                          axis_tlast,
    input  logic                          axis_tready
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2 * KW + USER_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Index of the final beat of an auto-mode packet; a length of 0 behaves as 1.
    function automatic logic [7:0] last_index(input logic [7:0] len);
        if (len == 8'd0) begin
            last_index = 8'd0;
        end else begin
            last_index = len - 8'd1;
        end
    endfunction

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    wr_beat_q, wr_beat_d;
    logic [7:0]    stall_q, stall_d;
    state_t        state_q, state_d;
    logic          nordy_q, nordy_d;
    logic          done_q, done_d;

    logic          wr_en_s;
    logic          rd_en_s;
    logic          last_s;
    logic [EW-1:0] wr_entry_s;
    logic [EW-1:0] head_s;

    assign bk_ready    = (level_q < LW'(FIFO_DEPTH));
    assign axis_tvalid = (level_q != LW'(0));
    assign wr_en_s     = bk_valid && bk_ready;
    assign rd_en_s     = axis_tvalid && axis_tready;
    assign last_s      = cfg_auto_last ? (wr_beat_q == last_index(cfg_pkt_len)) : bk_last;
    assign wr_entry_s  = {bk_data, bk_tstrb, bk_tkeep, bk_user, last_s};
    assign head_s      = mem_q[rd_ptr_q];

    assign axis_tdata  = head_s[EW-1 -: DATA_WIDTH];
    assign axis_tstrb  = head_s[EW-1-DATA_WIDTH -: KW];
    assign axis_tkeep  = head_s[EW-1-DATA_WIDTH-KW -: KW];
    assign axis_tuser  = head_s[USER_WIDTH:1];
    assign axis_tlast  = head_s[0];
    assign fifo_level  = level_q;
    assign bk_nordy    = nordy_q;
    assign bk_done     = done_q;

    // FIFO storage; cleared on reset so the idle head presents zeros.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s && !flush) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    // Pointer, occupancy and packet beat bookkeeping; flush overrides any transfer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wr_beat_d = wr_beat_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            wr_beat_d = 8'd0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (last_s) begin
                    wr_beat_d = 8'd0;
                end else begin
                    wr_beat_d = wr_beat_q + 8'd1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Packet-tracking FSM, stall watchdog and completion pulse.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            stall_d = 8'd0;
        end else begin
            done_d = rd_en_s && axis_tlast;
            case (state_q)
                ST_IDLE: begin
                    if (axis_tvalid) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (rd_en_s && axis_tlast && (level_d == LW'(0))) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Only stalls seen while streaming count towards the watchdog.
            if (rd_en_s || (state_q == ST_IDLE)) begin
                stall_d = 8'd0;
            end else if (axis_tvalid && !axis_tready && (stall_q != 8'hFF)) begin
                stall_d = stall_q + 8'd1;
            end else begin
                stall_d = stall_q;
            end
        end
        nordy_d = (stall_d >= 8'(RDY_TIMEOUT));
    end

    // Control state registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            wr_beat_q <= 8'd0;
            stall_q   <= 8'd0;
            state_q   <= ST_IDLE;
            nordy_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            wr_beat_q <= wr_beat_d;
            stall_q   <= stall_d;
            state_q   <= state_d;
            nordy_q   <= nordy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_axis_master_pkt.sv
// Directed bench for axis_master_pkt: explicit/auto TLAST, fill and stall, wrap, flush and async reset.
module tb_axis_master_pkt;

    logic        clk;
    logic        rst_n;
    logic        bk_valid;
    logic        bk_ready;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        cfg_auto_last;
    logic [7:0]  cfg_pkt_len;
    logic        flush;
    logic        bk_nordy;
    logic        bk_done;
    logic [3:0]  fifo_level;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic [1:0]  axis_tuser;
    logic        axis_tlast;
    logic        axis_tready;

    int n_checks = 0;
    int n_fails  = 0;

    axis_master_pkt #(
        .DATA_WIDTH(32), .USER_WIDTH(2), .FIFO_DEPTH(8), .RDY_TIMEOUT(5)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .bk_valid(bk_valid), .bk_ready(bk_ready), .bk_data(bk_data),
        .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep), .bk_user(bk_user), .bk_last(bk_last),
        .cfg_auto_last(cfg_auto_last), .cfg_pkt_len(cfg_pkt_len), .flush(flush),
        .bk_nordy(bk_nordy), .bk_done(bk_done), .fifo_level(fifo_level),
        .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tstrb(axis_tstrb),
        .axis_tkeep(axis_tkeep), .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
        .axis_tready(axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; bk_valid = 1'b0; bk_data = 32'h0; bk_tstrb = 4'hF; bk_tkeep = 4'hF;
        bk_user = 2'd0; bk_last = 1'b0; cfg_auto_last = 1'b0; cfg_pkt_len = 8'd0;
        flush = 1'b0; axis_tready = 1'b0;
        #1;
        chk("rst bk_ready", bk_ready, 1'b1);
        chk("rst tvalid", axis_tvalid, 1'b0);
        chk("rst level", fifo_level, 4'd0);
        chk("rst done", bk_done, 1'b0);
        chk("rst nordy", bk_nordy, 1'b0);
        chk("rst tdata", axis_tdata, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Explicit mode, four beats, ready held high
        axis_tready = 1'b1; bk_valid = 1'b1; bk_data = 32'h11;
        chk("t1 empty tvalid", axis_tvalid, 1'b0);
        tick();
        chk("t1 b1 tvalid", axis_tvalid, 1'b1);
        chk("t1 b1 data", axis_tdata, 32'h11);
        chk("t1 b1 last", axis_tlast, 1'b0);
        bk_data = 32'h22; bk_tstrb = 4'h3; bk_tkeep = 4'h7; bk_user = 2'd2;
        tick();
        chk("t1 b2 data", axis_tdata, 32'h22);
        chk("t1 b2 strb", axis_tstrb, 4'h3);
        chk("t1 b2 keep", axis_tkeep, 4'h7);
        chk("t1 b2 user", axis_tuser, 2'd2);
        chk("t1 b2 level", fifo_level, 4'd1);
        bk_data = 32'h33; bk_tstrb = 4'hF; bk_tkeep = 4'hF; bk_user = 2'd0;
        tick();
        chk("t1 b3 data", axis_tdata, 32'h33);
        chk("t1 b3 last", axis_tlast, 1'b0);
        bk_data = 32'h44; bk_last = 1'b1;
        tick();
        chk("t1 b4 data", axis_tdata, 32'h44);
        chk("t1 b4 last", axis_tlast, 1'b1);
        chk("t1 b4 done", bk_done, 1'b0);
        bk_valid = 1'b0; bk_last = 1'b0;
        tick();
        chk("t1 done pulse", bk_done, 1'b1);
        chk("t1 drained", axis_tvalid, 1'b0);
        tick();
        chk("t1 done low", bk_done, 1'b0);

        // Auto mode, packet length 3, seven beats
        cfg_auto_last = 1'b1; cfg_pkt_len = 8'd3; bk_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            bk_data = 32'(i);
            tick();
            chk("t2 data", axis_tdata, 64'(i));
            chk("t2 last", axis_tlast, (i == 3 || i == 6));
            chk("t2 done", bk_done, (i == 4 || i == 7));
        end
        bk_valid = 1'b0; axis_tready = 1'b0;
        tick();
        chk("t2 held valid", axis_tvalid, 1'b1);
        chk("t2 held data", axis_tdata, 32'h7);
        chk("t2 held last", axis_tlast, 1'b0);
        chk("t2 done low", bk_done, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t2 flush level", fifo_level, 4'd0);

        // Fill with ready low; watchdog trips on the fifth streaming stall
        cfg_auto_last = 1'b0; bk_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bk_data = 32'h100 + 32'(i);
            chk("t3 bk_ready", bk_ready, 1'b1);
            tick();
            chk("t3 level", fifo_level, 64'(i + 1));
            chk("t3 head stable", axis_tdata, 32'h100);
            chk("t3 nordy", bk_nordy, (i >= 6));
        end
        bk_valid = 1'b0;
        chk("t3 full ready", bk_ready, 1'b0);
        tick(); tick();
        chk("t3 nordy held", bk_nordy, 1'b1);
        chk("t3 head still", axis_tdata, 32'h100);
        chk("t3 level full", fifo_level, 4'd8);
        axis_tready = 1'b1;
        tick();
        chk("t3 nordy clear", bk_nordy, 1'b0);
        chk("t3 next head", axis_tdata, 32'h101);
        chk("t3 level 7", fifo_level, 4'd7);

        // Full FIFO, then one read and one write per cycle across the wrap
        axis_tready = 1'b0; bk_valid = 1'b1; bk_data = 32'h108;
        tick();
        chk("t4 level full", fifo_level, 4'd8);
        axis_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bk_data = 32'h109 + ((k == 0) ? 32'd0 : 32'(k - 1));
            chk("t4 head", axis_tdata, 64'(32'h101 + 32'(k)));
            chk("t4 bk_ready", bk_ready, (k != 0));
            tick();
            chk("t4 level", fifo_level, 4'd7);
        end
        bk_valid = 1'b0; axis_tready = 1'b0;
        chk("t4 final head", axis_tdata, 32'h115);
        chk("t4 nordy", bk_nordy, 1'b0);

        // Flush mid-packet at level 5, then the packet count restarts
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5 pre flush", fifo_level, 4'd0);
        cfg_auto_last = 1'b1; cfg_pkt_len = 8'd4; bk_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bk_data = 32'h200 + 32'(i);
            tick();
        end
        chk("t5 level 5", fifo_level, 4'd5);
        flush = 1'b1; axis_tready = 1'b1; bk_data = 32'h2FF;
        tick();
        flush = 1'b0;
        chk("t5 flushed level", fifo_level, 4'd0);
        chk("t5 flushed tvalid", axis_tvalid, 1'b0);
        chk("t5 no done", bk_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bk_data = 32'h300 + 32'(i);
            tick();
            chk("t5 data", axis_tdata, 64'(32'h300 + 32'(i)));
            chk("t5 last", axis_tlast, (i == 3));
        end
        bk_valid = 1'b0;
        tick();
        chk("t5 done", bk_done, 1'b1);
        chk("t5 drained", axis_tvalid, 1'b0);

        // Asynchronous reset in the middle of a stream
        axis_tready = 1'b0; bk_valid = 1'b1; bk_data = 32'h400; bk_user = 2'd1;
        tick();
        bk_data = 32'h401;
        tick();
        bk_valid = 1'b0;
        chk("t6 pre tvalid", axis_tvalid, 1'b1);
        chk("t6 pre level", fifo_level, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async tvalid", axis_tvalid, 1'b0);
        chk("t6 async level", fifo_level, 4'd0);
        chk("t6 async tdata", axis_tdata, 32'h0);
        chk("t6 async tuser", axis_tuser, 2'd0);
        chk("t6 async ready", bk_ready, 1'b1);
        chk("t6 async nordy", bk_nordy, 1'b0);
        chk("t6 async done", bk_done, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6 post ready", bk_ready, 1'b1);
        chk("t6 post tvalid", axis_tvalid, 1'b0);
        chk("t6 post level", fifo_level, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
